// File: rtl/seq_stream_ctrl.sv
// Sequencing controller for the MFA matching engine: fetches packed 2-bit symbols
// from a word-wide sequence memory and streams them gaplessly, one per clock.
module seq_stream_ctrl #(
  parameter int ADDR_LEN  = 6,
  parameter int DATA_LEN  = 8,
  parameter int SEQ_LEN_W = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [SEQ_LEN_W-1:0] seq_len,
  input  logic                 hold,
  output logic                 mem_rd,
  output logic [ADDR_LEN-1:0]  mem_addr,
  input  logic [DATA_LEN-1:0]  mem_rdata,
  output logic [1:0]           symbol,
  output logic                 sym_valid,
  output logic                 BC_mode,
  input  logic                 eng_done,
  output logic                 busy,
  output logic                 done,
  output logic [SEQ_LEN_W-1:0] sym_count
);

  localparam int SPW    = DATA_LEN / 2;
  localparam int WIDX_W = $clog2(SPW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                state_q, state_n;
  logic [SEQ_LEN_W-1:0]  seq_len_q;
  logic [SEQ_LEN_W-1:0]  cnt_q;
  logic [DATA_LEN-1:0]   shift_q;
  logic [DATA_LEN-1:0]   pf_buf_q;
  logic                  pf_pend_q;
  logic [WIDX_W-1:0]     widx_q;
  logic [ADDR_LEN-1:0]   wptr_q;

  logic emit;
  logic last_sym;
  logic word_end;
  logic more_words;
  logic prefetch;

  // A word is prefetched only if symbols remain beyond the end of the current word;
  // at the prefetch index the current word ends two symbols after cnt_q.
  assign more_words = {1'b0, seq_len_q} > ({1'b0, cnt_q} + (SEQ_LEN_W + 1)'(2));
  assign word_end   = (widx_q == WIDX_W'(SPW - 1));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state_q;
    emit      = 1'b0;
    last_sym  = 1'b0;
    prefetch  = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    symbol    = 2'b00;
    sym_valid = 1'b0;
    BC_mode   = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_n = (seq_len != '0) ? S_FETCH : S_FIN;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        BC_mode = 1'b1;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        BC_mode = 1'b1;
        if (!hold) begin
          emit      = 1'b1;
          sym_valid = 1'b1;
          symbol    = shift_q[1:0];
          last_sym  = ((cnt_q + SEQ_LEN_W'(1)) == seq_len_q);
          prefetch  = (widx_q == WIDX_W'(SPW - 2)) && more_words;
          mem_rd    = prefetch;
          if (last_sym) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        BC_mode = 1'b1;
        if (eng_done) state_n = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (mem_rd) mem_addr = wptr_q;
  end

  assign sym_count = cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: the data buffers are cleared on reset too, so a run aborted mid-word
      // or mid-prefetch leaves nothing behind for the next run.
      state_q   <= S_IDLE;
      seq_len_q <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      pf_buf_q  <= '0;
      pf_pend_q <= 1'b0;
      widx_q    <= '0;
      wptr_q    <= '0;
    end else begin
      state_q <= state_n;

      if (state_q == S_IDLE && start) begin
        seq_len_q <= seq_len;
        cnt_q     <= '0;
        wptr_q    <= '0;
      end

      if (state_q == S_LOAD) begin
        shift_q <= mem_rdata;
        widx_q  <= '0;
        wptr_q  <= ADDR_LEN'(1);
      end

      if (emit) begin
        cnt_q <= cnt_q + SEQ_LEN_W'(1);
        if (word_end) begin
          // The prefetched word may still be on the read bus this cycle.
          shift_q <= pf_pend_q ? mem_rdata : pf_buf_q;
          widx_q  <= '0;
        end else begin
          shift_q <= shift_q >> 2;
          widx_q  <= widx_q + WIDX_W'(1);
        end
      end

      if (prefetch) begin
        pf_pend_q <= 1'b1;
        wptr_q    <= wptr_q + ADDR_LEN'(1);
      end else if (pf_pend_q) begin
        pf_buf_q  <= mem_rdata;
        pf_pend_q <= 1'b0;
      end
    end
  end

endmodule
